// File: rtl/seq_mult_accumulator_pkg.sv
// rtl/seq_mult_accumulator_pkg.sv - shared defaults, state encoding and count width for seq_mult_accumulator
package seq_mult_accumulator_pkg;

  localparam int MX_W_DEF   = 16;
  localparam int MY_W_DEF   = 9;
  localparam int PROD_W_DEF = MX_W_DEF + MY_W_DEF;

  // Bit-count width for the default multiplier length
  localparam int CNT_W_DEF  = $clog2(MY_W_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } mult_state_t;

  // Counter width for an arbitrary multiplier length (at least one bit)
  function automatic int cnt_width(input int my_w);
    return (my_w > 1) ? $clog2(my_w) : 1;
  endfunction

endpackage

// File: rtl/seq_mult_accumulator_mult_bit_counter.sv
// rtl/seq_mult_accumulator_mult_bit_counter.sv - serial bit counter with clear, increment and last-bit flag
module mult_bit_counter
  import seq_mult_accumulator_pkg::*;
#(
  parameter int MY_W  = MY_W_DEF,
  parameter int CNT_W = cnt_width(MY_W)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_q;

  // Clear wins over increment so a new operation always starts from bit 0
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;
  assign last  = (count_q == CNT_W'(MY_W - 1));

endmodule

// File: rtl/seq_mult_accumulator.sv
// rtl/seq_mult_accumulator.sv - serial shift-and-add multiplier, signed mode under SEQ_MULT_SIGNED_EN
module seq_mult_accumulator
  import seq_mult_accumulator_pkg::*;
#(
  parameter int MX_W   = MX_W_DEF,
  parameter int MY_W   = MY_W_DEF,
  parameter int PROD_W = MX_W + MY_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [MX_W-1:0]   IN_MX,
  input  logic              MY_BIT,
  output logic              LD_MY,
  output logic              SFT_MY,
  output logic [PROD_W-1:0] PROD,
  output logic              BUSY,
  output logic              DONE
);

  localparam int CNT_W = cnt_width(MY_W);

  mult_state_t       state_q, state_d;
  logic [MX_W-1:0]   mx_q;
  logic [PROD_W-1:0] acc_q;
  logic [PROD_W-1:0] prod_q;
  logic [PROD_W-1:0] mx_ext;
  logic [PROD_W-1:0] pp;
  logic [PROD_W-1:0] acc_d;
  logic [CNT_W-1:0]  count;
  logic              last_bit;
  logic              accept;
  logic              cnt_inc;

  mult_bit_counter #(
    .MY_W  (MY_W),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr   (accept),
    .inc   (cnt_inc),
    .count (count),
    .last  (last_bit)
  );

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and strobes; START only matters while idle
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    cnt_inc = 1'b0;
    SFT_MY  = 1'b0;
    BUSY    = 1'b0;
    DONE    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          accept  = 1'b1;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        SFT_MY  = 1'b1;
        BUSY    = 1'b1;
        cnt_inc = 1'b1;
        if (last_bit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        BUSY    = 1'b1;
        DONE    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Load strobe is masked by reset so the shift source sees nothing while held in reset
  assign LD_MY = accept & RST_N;

  // Partial product for the current serial bit, and the running sum it produces
  always_comb begin
`ifdef SEQ_MULT_SIGNED_EN
    mx_ext = {{(PROD_W - MX_W){mx_q[MX_W-1]}}, mx_q};
    pp     = MY_BIT ? (mx_ext << count) : '0;
    // The multiplier's MSB carries negative weight in two's complement
    acc_d  = last_bit ? (acc_q - pp) : (acc_q + pp);
`else
    mx_ext = {{(PROD_W - MX_W){1'b0}}, mx_q};
    pp     = MY_BIT ? (mx_ext << count) : '0;
    acc_d  = acc_q + pp;
`endif
  end

  // Operand capture, accumulation, and product update on the final bit
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mx_q   <= '0;
      acc_q  <= '0;
      prod_q <= '0;
    end else if (accept) begin
      mx_q  <= IN_MX;
      acc_q <= '0;
    end else if (cnt_inc) begin
      acc_q <= acc_d;
      if (last_bit) begin
        prod_q <= acc_d;
      end
    end
  end

  assign PROD = prod_q;

endmodule

// File: tb/tb_seq_mult_accumulator.sv
// tb/tb_seq_mult_accumulator.sv - scoreboard bench for seq_mult_accumulator with a serial multiplier source
module tb_seq_mult_accumulator;

  localparam int MX_W   = 16;
  localparam int MY_W   = 9;
  localparam int PROD_W = 25;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              START = 1'b0;
  logic [MX_W-1:0]   IN_MX = '0;
  logic              MY_BIT;
  logic              LD_MY;
  logic              SFT_MY;
  logic [PROD_W-1:0] PROD;
  logic              BUSY;
  logic              DONE;

  logic [MY_W-1:0]   my_val = '0;
  logic [MY_W-1:0]   my_sr = '0;

  logic [PROD_W-1:0] exp_q[$];
  logic [PROD_W-1:0] last_prod = '0;
  int                n_vec = 0;
  int                n_err = 0;
  int                done_cnt = 0;
  int                cyc_ctr = 0;

  seq_mult_accumulator dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .START  (START),
    .IN_MX  (IN_MX),
    .MY_BIT (MY_BIT),
    .LD_MY  (LD_MY),
    .SFT_MY (SFT_MY),
    .PROD   (PROD),
    .BUSY   (BUSY),
    .DONE   (DONE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc_ctr <= cyc_ctr + 1;

  // Multiplier shift source: parallel load, then LSB-first serial shift
  always @(posedge CLK) begin
    if (LD_MY)       my_sr <= my_val;
    else if (SFT_MY) my_sr <= my_sr >> 1;
  end
  assign MY_BIT = my_sr[0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PROD_W-1:0] model(input logic [MX_W-1:0] mx, input logic [MY_W-1:0] my);
`ifdef SEQ_MULT_SIGNED_EN
    logic signed [PROD_W-1:0] a, b;
    a = $signed(mx);
    b = $signed(my);
    return a * b;
`else
    logic [PROD_W-1:0] a, b;
    a = {{(PROD_W-MX_W){1'b0}}, mx};
    b = {{(PROD_W-MY_W){1'b0}}, my};
    return a * b;
`endif
  endfunction

  // Scoreboard: every DONE pulse pops the oldest expected product
  always @(negedge CLK) begin
    if (RST_N && DONE) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(DONE), 32'd0);
      end else begin
        check("prod", 32'(PROD), 32'(exp_q.pop_front()));
      end
      check("busy_in_done", 32'(BUSY), 32'd1);
      check("sft_in_done", 32'(SFT_MY), 32'd0);
      done_cnt++;
    end
  end

  task automatic run_op(input logic [MX_W-1:0] mx, input logic [MY_W-1:0] my, input bit disturb);
    int cyc;
    @(negedge CLK);
    IN_MX  = mx;
    my_val = my;
    START  = 1'b1;
    #1;
    check("ld_my_idle", 32'(LD_MY), 32'd1);
    exp_q.push_back(model(mx, my));
    @(posedge CLK);
    cyc = 1;
    #1;
    START = 1'b0;
    while (cyc < 30) begin
      @(posedge CLK);
      cyc++;
      #1;
      if (cyc == 5) check("prod_hold", 32'(PROD), 32'(last_prod));
      if (disturb && cyc == 4) begin
        IN_MX = ~mx;
        START = 1'b1;
        #1;
        check("ld_my_accum", 32'(LD_MY), 32'd0);
      end
      if (cyc == 5) START = 1'b0;
      if (DONE) break;
    end
    check("latency", 32'(cyc), 32'd10);
    last_prod = model(mx, my);
    @(posedge CLK);
    #1;
    check("idle_after_done", 32'(BUSY), 32'd0);
  endtask

  initial begin
    int last_ld;
    int target;
    int w;
    logic [MX_W-1:0] mxs[3];
    logic [MY_W-1:0] mys[3];

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_prod", 32'(PROD), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_ld", 32'(LD_MY), 32'd0);
    check("rst_sft", 32'(SFT_MY), 32'd0);
    RST_N = 1'b1;

    // Directed vectors
    run_op(16'h0003, 9'h005, 1'b0);
`ifndef SEQ_MULT_SIGNED_EN
    check("prod_3x5", 32'(PROD), 32'h00000F);
`endif
    run_op(16'hFFFF, 9'h1FF, 1'b0);
`ifndef SEQ_MULT_SIGNED_EN
    check("prod_max", 32'(PROD), 32'h1FEFE01);
`endif
    run_op(16'hFFFD, 9'h005, 1'b0);
    run_op(16'h0002, 9'h1FF, 1'b0);
    run_op(16'h0000, 9'h1AB, 1'b0);
    run_op(16'h8001, 9'h100, 1'b0);

    // Operand change and START pulse mid-operation
    run_op(16'h1234, 9'h0A5, 1'b1);

    // Random vectors
    for (int i = 0; i < 6; i++) begin
      run_op(16'($urandom), 9'($urandom), 1'b0);
    end

    // START held high: back-to-back operations, one load per operation
    mxs[0] = 16'h00FF; mys[0] = 9'h003;
    mxs[1] = 16'hABCD; mys[1] = 9'h155;
    mxs[2] = 16'h7FFF; mys[2] = 9'h0FF;
    target  = done_cnt + 3;
    last_ld = 0;
    @(negedge CLK);
    IN_MX  = mxs[0];
    my_val = mys[0];
    START  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      w = 0;
      #1;
      while (!LD_MY && w < 30) begin
        @(negedge CLK);
        #1;
        w++;
      end
      check("b2b_ld_seen", 32'(LD_MY), 32'd1);
      exp_q.push_back(model(mxs[k], mys[k]));
      if (k > 0) check("b2b_gap", 32'(cyc_ctr - last_ld), 32'd11);
      last_ld = cyc_ctr;
      @(posedge CLK);
      #1;
      check("b2b_no_reload", 32'(LD_MY), 32'd0);
      if (k < 2) begin
        IN_MX  = mxs[k+1];
        my_val = mys[k+1];
      end else begin
        START = 1'b0;
      end
      @(negedge CLK);
    end
    w = 0;
    while (done_cnt < target && w < 40) begin
      @(posedge CLK);
      w++;
    end
    check("b2b_done_count", 32'(done_cnt), 32'(target));
    last_prod = model(mxs[2], mys[2]);
    repeat (2) @(posedge CLK);

    // Reset on the 5th ACCUM cycle aborts the operation
    @(negedge CLK);
    IN_MX  = 16'h4321;
    my_val = 9'h1F0;
    START  = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    check("abort_prod", 32'(PROD), 32'd0);
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_sft", 32'(SFT_MY), 32'd0);
    check("abort_done", 32'(DONE), 32'd0);
    last_prod = '0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (15) @(posedge CLK);
    check("abort_no_done", 32'(exp_q.size()), 32'd0);
    run_op(16'h0123, 9'h07B, 1'b0);

    repeat (3) @(posedge CLK);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/seq_mult_accumulator.md
SEQ_MULT_ACCUMULATOR -- requirements
Module: seq_mult_accumulator

Interface
REQ-001 Parameter MX_W, 16: multiplicand width.
REQ-002 Parameter MY_W, 9: multiplier width, equal to the number of serial bits consumed per operation.
REQ-003 Parameter PROD_W, MX_W+MY_W (25): product width.
REQ-004 Port CLK, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port RST_N, input, 1: asynchronous, active-low reset.
REQ-006 Port START, input, 1: request a new multiply; sampled only in IDLE.
REQ-007 Port IN_MX, input, MX_W: multiplicand; captured on the edge that accepts START.
REQ-008 Port MY_BIT, input, 1: serial multiplier bit from the multiplier shift source, LSB first.
REQ-009 Port LD_MY, output, 1: load strobe to the multiplier shift source.
REQ-010 Port SFT_MY, output, 1: shift strobe to the multiplier shift source.
REQ-011 Port PROD, output, PROD_W: registered product.
REQ-012 Port BUSY, output, 1: high in ACCUM and DONE.
REQ-013 Port DONE, output, 1: one-cycle pulse; PROD is valid.

Function
REQ-014 FSM states: IDLE, ACCUM, DONE.
REQ-015 IDLE with START=1: LD_MY=1 combinationally in that cycle; at the edge, latch IN_MX, clear accumulator and bit count, go to ACCUM.
REQ-016 IDLE with START=0: stay in IDLE; LD_MY=0, SFT_MY=0.
REQ-017 ACCUM: SFT_MY=1 every cycle; at each edge, add (MY_BIT ? MX << count : 0) to the PROD_W-bit accumulator and increment count.
REQ-018 ACCUM exit: on the edge that consumes bit MY_W-1, copy the final accumulator sum to PROD and go to DONE.
REQ-019 DONE: DONE=1 for exactly one cycle; SFT_MY=0; next state is IDLE unconditionally.
REQ-020 Latency: START accepted at edge N; DONE is high in the cycle following edge N+MY_W (10 cycles for defaults).
REQ-021 PROD changes only on the ACCUM-to-DONE transition; it holds through IDLE and the next ACCUM.
REQ-022 START in ACCUM or DONE is ignored; no queuing; LD_MY stays 0.
REQ-023 IN_MX changes after acceptance have no effect on the current operation.
REQ-024 Arithmetic is unsigned (macro absent); the accumulator never overflows PROD_W.
REQ-025 Back-to-back operation: START may be accepted in the IDLE cycle immediately after DONE.

Reset
REQ-026 RST_N low forces immediately: state IDLE, count 0, MX 0, accumulator 0, PROD 0, DONE 0, BUSY 0, LD_MY 0, SFT_MY 0.
REQ-027 Reset during ACCUM or DONE aborts the operation; no DONE pulse follows; PROD reads 0.
REQ-028 START is ignored on the first edge after RST_N deasserts only if RST_N is still low at that edge.

Configuration
REQ-029 Macro SEQ_MULT_SIGNED_EN defined: IN_MX and the serial multiplier are two's complement; partial products are sign-extended to PROD_W; the bit at count MY_W-1 subtracts (MX << (MY_W-1)) instead of adding it; PROD is the signed product.
REQ-030 Macro SEQ_MULT_SIGNED_EN undefined: unsigned behaviour per REQ-024; no sign-extension logic is present.

Structure
REQ-031 The shared package holds MX_W, MY_W, PROD_W defaults, the FSM state enumeration, and the count width $clog2(MY_W).
REQ-032 One sub-module, mult_bit_counter, holds the count with clear, increment, and a last-bit flag (count==MY_W-1).
REQ-033 The bench pairs this block with the existing multiplier shift source, connecting LD_MY, SFT_MY, and MY_BIT.

Verification
REQ-034 Stimulus IN_MX=16'h0003, MY=9'h005 -> PROD=25'h00000F; DONE high exactly 10 cycles after START is accepted.
REQ-035 Stimulus IN_MX=16'hFFFF, MY=9'h1FF, unsigned -> PROD=25'h1FEFE01.
REQ-036 Stimulus START held high continuously -> operations run back-to-back; the next START is accepted only in IDLE after DONE; LD_MY pulses once per operation.
REQ-037 Stimulus RST_N low on the 5th ACCUM cycle -> all outputs 0 immediately; no DONE pulse; the next operation from IDLE is correct.
REQ-038 With SEQ_MULT_SIGNED_EN: IN_MX=16'hFFFD (-3), MY=9'h005 -> PROD=25'h1FFFFF1 (-15); IN_MX=16'h0002, MY=9'h1FF (-1) -> PROD=25'h1FFFFFE (-2).
REQ-039 Stimulus IN_MX changed and START pulsed during ACCUM -> result reflects the originally latched MX; no restart occurs.
